// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC and IR, fetches one word per updPC edge, resolves the next PC.
// Latency: the request goes out in the cycle after the updPC edge, and IR is valid the cycle after the ack.
// Backpressure: the fetch request and address are held until imem_ack; updPC edges while a fetch is pending raise seq_err.
module fetch_unit #(
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            updPC,
    input  logic [2:0]      brOp,
    input  logic            neg,
    input  logic            zero,
    output logic [AW-1:0]   imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [AW-1:0]   pc,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      func,
    output logic [15:0]     imm,
    output logic            ir_valid,
    output logic [31:0]     instr_count,
    output logic            seq_err
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] PC_STEP = AW'(4);

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            seq_err_q, seq_err_d;
    logic            updpc_q;

    logic            upd_evt;
    logic            br_taken;
    logic [AW-1:0]   br_off;
    logic [AW-1:0]   pc4;
    logic [AW-1:0]   tgt;

    // Word offset: sign-extended imm shifted left by two, fitted to AW bits.
    for (genvar g = 0; g < AW; g++) begin : g_off
        if (g < 2) begin : g_lo
            assign br_off[g] = 1'b0;
        end else if (g < 18) begin : g_mid
            assign br_off[g] = ir_q[g-2];
        end else begin : g_hi
            assign br_off[g] = ir_q[15];
        end
    end

    assign pc4     = pc_q + PC_STEP;
    assign tgt     = pc4 + br_off;
    assign upd_evt = updPC & ~updpc_q;

    always_comb begin
        br_taken = 1'b0;
        case (brOp)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = neg;
            3'b010:  br_taken = ~neg & ~zero;
            3'b011:  br_taken = zero;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        cnt_d      = cnt_q;
        seq_err_d  = seq_err_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    ir_valid_d = 1'b1;
                    cnt_d      = cnt_q + 32'd1;
                    state_d    = S_READY;
                end
                // An edge with no instruction in hand is dropped, only flagged.
                if (upd_evt) begin
                    seq_err_d = 1'b1;
                end
            end
            S_READY: begin
                if (upd_evt) begin
                    pc_d       = br_taken ? tgt : pc4;
                    ir_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            cnt_q      <= '0;
            seq_err_q  <= 1'b0;
            updpc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            cnt_q      <= cnt_d;
            seq_err_q  <= seq_err_d;
            updpc_q    <= updPC;
        end
    end

    // Request is masked during reset so a late ack can never be taken.
    assign imem_req    = (state_q == S_FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign func        = ir_q[4:0];
    assign imm         = ir_q[15:0];
    assign ir_valid    = ir_valid_q;
    assign instr_count = cnt_q;
    assign seq_err     = seq_err_q;

endmodule
